// File: rtl/in_unit_fifo_rc.sv
// Router input unit: flit FIFO with upstream back-pressure, XY route computation
// on head flits, and a per-packet output-port request to the switch allocator.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module in_unit_fifo_rc #(
  parameter int DEPTH   = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [`DATA_WIDTH-1:0]   data_in,
  input  logic                     data_valid,
  output logic                     full,
  output logic [`DATA_WIDTH-1:0]   data_out,
  output logic [3:0]               req,
  input  logic                     gnt,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int DATA_W = `DATA_WIDTH;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, ROUTED} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic [3:0]        route_q, route_d;
  logic              err_q;
  logic              empty, push, pop, grant_pop, drop, head_ok;
  logic [DATA_W-1:0] head;
  logic [1:0]        head_type;
  logic [2:0]        head_dx;
  logic              head_dy;

  function automatic logic [3:0] xy_route(input logic [2:0] dx, input logic dy);
    if (dx < 3'(LOCAL_X))      return 4'b0001;
    else if (dx > 3'(LOCAL_X)) return 4'b0010;
    else if (dy != 1'(LOCAL_Y)) return 4'b0100;
    else                       return 4'b1000;
  endfunction

  assign head      = mem[rd_ptr];
  assign head_type = head[DATA_W-1:DATA_W-2];
  assign head_dx   = head[DATA_W-3:DATA_W-5];
  assign head_dy   = head[DATA_W-6];

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign err      = err_q;
  assign data_out = empty ? '0 : head;

  // The route is held through packet gaps; the request only shows while a flit is buffered.
  assign req = (state_q == ROUTED && !empty) ? route_q : 4'b0000;

  assign head_ok   = (head_type == T_HEAD || head_type == T_SINGLE) && (head_dx <= 3'd3);
  assign drop      = (state_q == IDLE) && !empty && !head_ok;
  assign grant_pop = gnt && (req != 4'b0000);
  assign push      = data_valid && !full;
  assign pop       = grant_pop || drop;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      IDLE: begin
        if (!empty && head_ok) begin
          route_d = xy_route(head_dx, head_dy);
          state_d = ROUTED;
        end
      end
      ROUTED: begin
        if (grant_pop && (head_type == T_TAIL || head_type == T_SINGLE)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      err_q   <= drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Flit storage carries no reset; data_out is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule
